// File: rtl/vigna_bus_arbiter.sv
// Merges vigna instruction and data ports onto one registered valid/ready bus.
// Define ARB_RR_EN for round-robin arbitration instead of fixed D_PRIORITY.
module vigna_bus_arbiter #(
   parameter bit          D_PRIORITY  = 1'b1,
   parameter logic [31:0] I_RDATA_RST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_valid,
   output logic        i_ready,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wstrb,
   input  logic        d_valid,
   output logic        d_ready,
   input  logic [31:0] d_addr,
   output logic [31:0] d_rdata,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_addr,
   input  logic [31:0] m_rdata,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t state, state_nx;
   logic   grant_d;
   logic   pick_d;
   logic   req;

   assign req = i_valid | d_valid;

`ifdef ARB_RR_EN
   logic last_d;

   // A lone requester wins outright; on a tie the port not served last wins.
   always_comb pick_d = d_valid & (~i_valid | ~last_d);

   always_ff @(posedge clk) begin
      if (!resetn)
         last_d <= 1'b0;
      else if (state == IDLE && req)
         last_d <= pick_d;
   end
`else
   always_comb pick_d = d_valid & (~i_valid | D_PRIORITY);
`endif

   always_ff @(posedge clk) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (req) state_nx = BUSY;
         BUSY:    if (m_ready) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         m_valid <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_wstrb <= '0;
         grant_d <= 1'b0;
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         i_rdata <= I_RDATA_RST;
         d_rdata <= '0;
      end else begin
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req) begin
                  m_valid <= 1'b1;
                  grant_d <= pick_d;
                  m_addr  <= pick_d ? d_addr  : i_addr;
                  m_wdata <= pick_d ? d_wdata : i_wdata;
                  m_wstrb <= pick_d ? d_wstrb : i_wstrb;
               end
            end
            BUSY: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  if (grant_d) begin
                     d_rdata <= m_rdata;
                     d_ready <= 1'b1;
                  end else begin
                     i_rdata <= m_rdata;
                     i_ready <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Directed self-checking bench for vigna_bus_arbiter.
// Covers reset, fetch, stalled store, arbitration, read-data hold, mid-reset.
module tb_vigna_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, i_ready;
  logic [31:0] i_addr, i_rdata, i_wdata;
  logic [3:0]  i_wstrb;
  logic        d_valid, d_ready;
  logic [31:0] d_addr, d_rdata, d_wdata;
  logic [3:0]  d_wstrb;
  logic        m_valid, m_ready;
  logic [31:0] m_addr, m_rdata, m_wdata;
  logic [3:0]  m_wstrb;

  int n_cmp = 0;
  int n_err = 0;

  vigna_bus_arbiter dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr),
    .d_rdata(d_rdata), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_rdata(m_rdata), .m_wdata(m_wdata), .m_wstrb(m_wstrb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] ref_v);
    n_cmp++;
    if (obs !== ref_v) begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, ref_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input bit is_d,
                     input logic [31:0] addr,
                     input logic [31:0] rd);
    m_ready = 1'b1;
    m_rdata = rd;
    tick();
    chk("txn_mvalid", m_valid, 1'b1);
    chk("txn_maddr", m_addr, addr);
    tick();
    chk("txn_mvalid_lo", m_valid, 1'b0);
    chk("txn_iready", i_ready, !is_d);
    chk("txn_dready", d_ready, is_d);
    if (is_d)
      chk("txn_drdata", d_rdata, rd);
    else
      chk("txn_irdata", i_rdata, rd);
    tick();
    chk("txn_resp_iready", i_ready, 1'b0);
    chk("txn_resp_dready", d_ready, 1'b0);
  endtask

  initial begin
    resetn  = 1'b0;
    i_valid = 1'b0; i_addr = '0;
    i_wdata = '0; i_wstrb = '0;
    d_valid = 1'b0; d_addr = '0;
    d_wdata = '0; d_wstrb = '0;
    m_ready = 1'b1; m_rdata = '0;

    tick();
    tick();
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_iready", i_ready, 1'b0);
    chk("rst_dready", d_ready, 1'b0);
    chk("rst_irdata", i_rdata, 32'h0000_0013);
    chk("rst_drdata", d_rdata, 32'h0);
    chk("rst_maddr", m_addr, 32'h0);

    resetn  = 1'b1;
    i_valid = 1'b1;
    i_addr  = 32'h0;
    m_rdata = 32'h0050_0093;
    tick();
    chk("f0_mvalid", m_valid, 1'b1);
    chk("f0_maddr", m_addr, 32'h0);
    chk("f0_iready", i_ready, 1'b0);
    tick();
    chk("f0_iready_pulse", i_ready, 1'b1);
    chk("f0_irdata", i_rdata, 32'h0050_0093);
    chk("f0_mvalid_lo", m_valid, 1'b0);
    i_valid = 1'b0;
    tick();
    chk("f0_iready_end", i_ready, 1'b0);

    m_ready = 1'b0;
    m_rdata = 32'h1111_1111;
    d_valid = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'hDEAD_BEEF;
    d_wstrb = 4'b0011;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("st_mvalid", m_valid, 1'b1);
      chk("st_maddr", m_addr, 32'h100);
      chk("st_mwdata", m_wdata, 32'hDEAD_BEEF);
      chk("st_mwstrb", m_wstrb, 4'b0011);
      chk("st_dready_wait", d_ready, 1'b0);
      tick();
    end
    chk("st_mvalid_hold", m_valid, 1'b1);
    m_ready = 1'b1;
    tick();
    chk("st_dready", d_ready, 1'b1);
    chk("st_drdata", d_rdata, 32'h1111_1111);
    chk("st_irdata_kept", i_rdata, 32'h0050_0093);
    d_valid = 1'b0;
    d_wstrb = 4'b0000;
    tick();
    chk("st_dready_single", d_ready, 1'b0);
    tick();
    chk("st_idle_mvalid", m_valid, 1'b0);

`ifndef ARB_RR_EN
    i_valid = 1'b1; i_addr = 32'h4;
    d_valid = 1'b1; d_addr = 32'h200;
    m_rdata = 32'hAAAA_0001;
    tick();
    chk("sim_first_maddr", m_addr, 32'h200);
    tick();
    chk("sim_dready", d_ready, 1'b1);
    chk("sim_iready0", i_ready, 1'b0);
    chk("sim_drdata", d_rdata, 32'hAAAA_0001);
    chk("sim_irdata_kept", i_rdata, 32'h0050_0093);
    d_valid = 1'b0;
    m_rdata = 32'hBBBB_0002;
    tick();
    chk("sim_resp_mvalid", m_valid, 1'b0);
    tick();
    chk("sim_second_mvalid", m_valid, 1'b1);
    chk("sim_second_maddr", m_addr, 32'h4);
    tick();
    chk("sim_iready", i_ready, 1'b1);
    chk("sim_irdata", i_rdata, 32'hBBBB_0002);
    chk("sim_drdata_kept", d_rdata, 32'hAAAA_0001);
    i_valid = 1'b0;
    tick();
`else
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    i_valid = 1'b1; i_addr = 32'h4;
    d_valid = 1'b1; d_addr = 32'h200;
    txn(1'b1, 32'h200, 32'hAAAA_0001);
    txn(1'b0, 32'h4,   32'hAAAA_0002);
    txn(1'b1, 32'h200, 32'hAAAA_0003);
    txn(1'b0, 32'h4,   32'hAAAA_0004);
    i_valid = 1'b0;
    d_valid = 1'b0;
    tick();
`endif

    i_valid = 1'b1; i_addr = 32'h8;
    txn(1'b0, 32'h8, 32'h0050_0093);
    i_valid = 1'b0;
    d_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d_addr = 32'h400 + 32'(k * 4);
      txn(1'b1, 32'h400 + 32'(k * 4),
          32'hC0DE_0000 + 32'(k));
      chk("hold_irdata", i_rdata, 32'h0050_0093);
    end
    chk("hold_drdata_last", d_rdata, 32'hC0DE_0002);
    d_valid = 1'b0;
    tick();

    m_ready = 1'b0;
    d_valid = 1'b1;
    d_addr  = 32'h300;
    tick();
    chk("mr_busy_mvalid", m_valid, 1'b1);
    tick();
    chk("mr_wait_mvalid", m_valid, 1'b1);
    resetn = 1'b0;
    tick();
    chk("mr_rst_mvalid", m_valid, 1'b0);
    chk("mr_rst_dready", d_ready, 1'b0);
    chk("mr_rst_irdata", i_rdata, 32'h0000_0013);
    resetn = 1'b1;
    txn(1'b1, 32'h300, 32'hCCCC_0005);
    d_valid = 1'b0;
    tick();
    chk("end_idle_mvalid", m_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
